// File: rtl/step_dir_gen.sv
// -----------------------------------------------------------------------------
// step_dir_gen
// Step/direction generator. It accepts a target position over a valid/ready
// handshake and walks a downstream up/down counter to that target. It does
// this by emitting one-cycle step pulses (o_en) with a held direction
// (o_mode). The block keeps a shadow copy of the counter value (o_pos) and
// pulses o_done when the target is reached.
//
// Ports
//   i_clk        system clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_tgt_valid  target offered
//   o_tgt_ready  target can be accepted (high exactly while idle)
//   i_tgt        target position, unsigned, N bits
//   i_interval   idle cycles between steps, sampled at acceptance
//   i_abort      synchronous cancel of the current move
//   o_en         step pulse, one cycle per step
//   o_mode       step direction, 1 = increment, 0 = decrement
//   o_pos        shadow position, tracks the downstream counter
//   o_busy       move in progress
//   o_done       one-cycle pulse when the target is reached
// -----------------------------------------------------------------------------
module step_dir_gen #(
   parameter int unsigned N  = 10,
   parameter int unsigned DW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_tgt_valid,
   output logic          o_tgt_ready,
   input  logic [N-1:0]  i_tgt,
   input  logic [DW-1:0] i_interval,
   input  logic          i_abort,
   output logic          o_en,
   output logic          o_mode,
   output logic [N-1:0]  o_pos,
   output logic          o_busy,
   output logic          o_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [N-1:0]  LP_POS_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] LP_TMR_ONE = {{(DW-1){1'b0}}, 1'b1};

   logic [1:0]    r_state, w_state_nx;
   logic [N-1:0]  r_pos,   w_pos_nx;
   logic          r_mode,  w_mode_nx;
   logic          r_en,    w_en_nx;
   logic          r_done,  w_done_nx;
   logic [N-1:0]  r_tgt,   w_tgt_nx;
   logic [DW-1:0] r_interval, w_interval_nx;
   logic [DW-1:0] r_timer, w_timer_nx;
   logic [N-1:0]  w_pos_step;

   // Position after the step that is in flight this cycle.
   assign w_pos_step = r_mode ? (r_pos + LP_POS_ONE) : (r_pos - LP_POS_ONE);

   always_comb begin
      w_state_nx    = r_state;
      w_pos_nx      = r_pos;
      w_mode_nx     = r_mode;
      w_done_nx     = 1'b0;
      w_tgt_nx      = r_tgt;
      w_interval_nx = r_interval;
      w_timer_nx    = r_timer;
      case (r_state)
         ST_IDLE: begin
            if (i_tgt_valid) begin
               w_tgt_nx      = i_tgt;
               w_interval_nx = i_interval;
               if (i_tgt == r_pos) begin
                  w_done_nx = 1'b1;
               end else begin
                  // Direction by magnitude only, so a move never wraps.
                  w_mode_nx  = (i_tgt > r_pos);
                  w_state_nx = ST_STEP;
               end
            end
         end
         ST_STEP: begin
            // The pulse high this cycle always completes, even on abort.
            w_pos_nx = w_pos_step;
            if (i_abort) begin
               w_state_nx = ST_IDLE;
            end else if (w_pos_step == r_tgt) begin
               w_state_nx = ST_IDLE;
               w_done_nx  = 1'b1;
            end else if (r_interval == '0) begin
               w_state_nx = ST_STEP;
            end else begin
               w_state_nx = ST_WAIT;
               w_timer_nx = r_interval;
            end
         end
         ST_WAIT: begin
            w_timer_nx = r_timer - LP_TMR_ONE;
            if (i_abort) begin
               w_state_nx = ST_IDLE;
            end else if (r_timer == LP_TMR_ONE) begin
               w_state_nx = ST_STEP;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
      // en is a registered copy of "next state is STEP".
      w_en_nx = (w_state_nx == ST_STEP);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_pos      <= '0;
         r_mode     <= 1'b1;
         r_en       <= 1'b0;
         r_done     <= 1'b0;
         r_tgt      <= '0;
         r_interval <= '0;
         r_timer    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_pos      <= w_pos_nx;
         r_mode     <= w_mode_nx;
         r_en       <= w_en_nx;
         r_done     <= w_done_nx;
         r_tgt      <= w_tgt_nx;
         r_interval <= w_interval_nx;
         r_timer    <= w_timer_nx;
      end
   end

   assign o_tgt_ready = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_en        = r_en;
   assign o_mode      = r_mode;
   assign o_pos       = r_pos;
   assign o_done      = r_done;

endmodule

// File: tb/tb_step_dir_gen.sv
// -----------------------------------------------------------------------------
// tb_step_dir_gen
// Self-checking bench for step_dir_gen. The reference keeps a per-cycle
// schedule of expected outputs. When a target is accepted, the schedule is
// filled from the closed-form timing rules: en at 1 + k(I+1), done at
// 2 + (d-1)(I+1). Abort truncates the schedule. Directed moves add literal
// expectations, and a model of the downstream counter (falling-edge sampled)
// is checked against the shadow position.
// -----------------------------------------------------------------------------
module tb_step_dir_gen;

   localparam int N    = 10;
   localparam int DW   = 16;
   localparam int MAXC = 65536;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          tgt_valid = 1'b0;
   logic          abort     = 1'b0;
   logic [N-1:0]  tgt       = '0;
   logic [DW-1:0] interval  = '0;
   logic          o_tgt_ready, o_en, o_mode, o_busy, o_done;
   logic [N-1:0]  o_pos;

   always #5 clk = ~clk;

   step_dir_gen #(.N(N), .DW(DW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_tgt_valid (tgt_valid),
      .o_tgt_ready (o_tgt_ready),
      .i_tgt       (tgt),
      .i_interval  (interval),
      .i_abort     (abort),
      .o_en        (o_en),
      .o_mode      (o_mode),
      .o_pos       (o_pos),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   // Downstream up/down counter, sampling on the falling edge.
   logic [N-1:0] cnt;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (o_en) cnt <= o_mode ? cnt + 1'b1 : cnt - 1'b1;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc    = 0;
   int m_last = 0;
   bit chk_en = 1'b0;

   // Expected outputs per cycle index, valid up to m_last; later cycles hold.
   bit           x_en   [MAXC];
   bit           x_done [MAXC];
   bit           x_busy [MAXC];
   bit           x_mode [MAXC];
   logic [N-1:0] x_pos  [MAXC];

   task automatic chk(input string name, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic extend_to(input int c);
      while (m_last < c) begin
         m_last++;
         x_en[m_last]   = 1'b0;
         x_done[m_last] = 1'b0;
         x_busy[m_last] = 1'b0;
         x_mode[m_last] = x_mode[m_last-1];
         x_pos[m_last]  = x_pos[m_last-1];
      end
   endtask

   task automatic model_accept(input int c, input int t, input int iv);
      int p, d, dn, n;
      bit up;
      p = int'(x_pos[c]);
      if (t == p) begin
         x_en[c+1]   = 1'b0;
         x_done[c+1] = 1'b1;
         x_busy[c+1] = 1'b0;
         x_mode[c+1] = x_mode[c];
         x_pos[c+1]  = x_pos[c];
         m_last      = c + 1;
      end else begin
         up = (t > p);
         d  = up ? t - p : p - t;
         dn = c + 2 + (d - 1) * (iv + 1);
         for (int k = c + 1; k <= dn; k++) begin
            n         = (k >= c + 2) ? (k - c - 2) / (iv + 1) + 1 : 0;
            x_pos[k]  = N'(up ? p + n : p - n);
            x_en[k]   = (k < dn) && ((k - c - 1) % (iv + 1) == 0);
            x_busy[k] = (k < dn);
            x_done[k] = (k == dn);
            x_mode[k] = up;
         end
         m_last = dn;
      end
   endtask

   task automatic model_abort(input int c);
      int np;
      np = int'(x_pos[c]);
      if (x_en[c]) np = x_mode[c] ? np + 1 : np - 1;
      x_en[c+1]   = 1'b0;
      x_done[c+1] = 1'b0;
      x_busy[c+1] = 1'b0;
      x_mode[c+1] = x_mode[c];
      x_pos[c+1]  = N'(np);
      m_last      = c + 1;
   endtask

   task automatic resync();
      x_en[cyc]   = 1'b0;
      x_done[cyc] = 1'b0;
      x_busy[cyc] = 1'b0;
      x_mode[cyc] = 1'b1;
      x_pos[cyc]  = '0;
      m_last      = cyc;
   endtask

   // Per-cycle comparison against the schedule.
   always @(negedge clk) begin : cmp
      int c;
      bit ee, ed, eb, em;
      logic [N-1:0] ep;
      if (chk_en) begin
         c = cyc;
         if (c <= m_last) begin
            ee = x_en[c]; ed = x_done[c]; eb = x_busy[c]; em = x_mode[c]; ep = x_pos[c];
         end else begin
            ee = 1'b0; ed = 1'b0; eb = 1'b0; em = x_mode[m_last]; ep = x_pos[m_last];
         end
         chk("en",    int'(o_en),        int'(ee));
         chk("done",  int'(o_done),      int'(ed));
         chk("busy",  int'(o_busy),      int'(eb));
         chk("ready", int'(o_tgt_ready), int'(!eb));
         chk("mode",  int'(o_mode),      int'(em));
         chk("pos",   int'(o_pos),       int'(ep));
      end
   end

   // Drive one cycle of inputs, update the model, advance to the next cycle.
   task automatic step_cycle(input bit v, input logic [N-1:0] t, input logic [DW-1:0] iv,
                             input bit ab);
      tgt_valid = v; tgt = t; interval = iv; abort = ab;
      if (chk_en) begin
         extend_to(cyc);
         if (ab && x_busy[cyc])       model_abort(cyc);
         else if (v && !x_busy[cyc])  model_accept(cyc, int'(t), int'(iv));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC - 2100) begin
         $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC - 2100);
         $fatal(1);
      end
   endtask

   task automatic run_move(input logic [N-1:0] t, input logic [DW-1:0] iv, input int ncyc,
                           input int abort_at, input bit junk,
                           output logic [63:0] en_mask, output logic [63:0] rdy_mask,
                           output int en_cnt, output int done_cnt, output int done_at,
                           output bit last_mode);
      en_mask = '0; rdy_mask = '0; en_cnt = 0; done_cnt = 0; done_at = -1; last_mode = 1'b0;
      step_cycle(1'b1, t, iv, 1'b0);
      for (int k = 1; k <= ncyc; k++) begin
         if (o_en) begin
            if (k < 64) en_mask[k] = 1'b1;
            en_cnt++;
            last_mode = o_mode;
         end
         if (o_done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (o_tgt_ready && k < 64) rdy_mask[k] = 1'b1;
         step_cycle(junk && k >= 2 && (abort_at == 0 || k < abort_at), 10'd500, 16'd7,
                    k == abort_at);
      end
   endtask

   logic [63:0] em, rm;
   int ec, dc, da;
   bit lm;

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_en",    int'(o_en),        0);
      chk("rst_pos",   int'(o_pos),       0);
      chk("rst_mode",  int'(o_mode),      1);
      chk("rst_done",  int'(o_done),      0);
      chk("rst_ready", int'(o_tgt_ready), 1);
      chk("rst_busy",  int'(o_busy),      0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      resync();
      chk("post_rst_pos",   int'(o_pos),       0);
      chk("post_rst_mode",  int'(o_mode),      1);
      chk("post_rst_ready", int'(o_tgt_ready), 1);
      chk_en = 1'b1;

      // Count up with spacing: 0 -> 3, interval 2.
      run_move(10'd3, 16'd2, 8, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("up_en_mask", int'(em[31:0]), 32'h92);
      chk("up_done_at", da, 8);
      chk("up_mode",    int'(lm), 1);
      chk("up_pos",     int'(o_pos), 3);
      chk("up_cnt",     int'(cnt), 3);

      // Reposition to 5, then count down back-to-back: 5 -> 1.
      run_move(10'd5, 16'd0, 3, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("to5_pos", int'(o_pos), 5);
      run_move(10'd1, 16'd0, 5, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("dn_en_mask", int'(em[31:0]), 32'h1E);
      chk("dn_done_at", da, 5);
      chk("dn_mode",    int'(lm), 0);
      chk("dn_pos",     int'(o_pos), 1);
      chk("dn_cnt",     int'(cnt), 1);

      // Edge of range, no wrap: 1 -> 1023.
      run_move(10'd1023, 16'd0, 1023, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("long_en_cnt",  ec, 1022);
      chk("long_done_at", da, 1023);
      chk("long_mode",    int'(lm), 1);
      chk("long_pos",     int'(o_pos), 1023);
      chk("long_cnt",     int'(cnt), 1023);

      // Equal target.
      run_move(10'd1023, 16'd5, 2, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("eq_en_cnt",   ec, 0);
      chk("eq_done_at",  da, 1);
      chk("eq_done_cnt", dc, 1);

      // Back to 0, then abort in WAIT after the 2nd step with junk valid.
      run_move(10'd0, 16'd0, 1024, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("home_done_at", da, 1024);
      chk("home_pos",     int'(o_pos), 0);
      run_move(10'd10, 16'd3, 12, 6, 1'b1, em, rm, ec, dc, da, lm);
      chk("ab_en_mask",  int'(em[31:0]), 32'h22);
      chk("ab_done_cnt", dc, 0);
      chk("ab_ready",    int'(rm[15:0] & 16'h1FFE), 16'h1F80);
      chk("ab_pos",      int'(o_pos), 2);
      chk("ab_cnt",      int'(cnt), 2);

      // Reset in the middle of a STEP cycle.
      step_cycle(1'b1, 10'd40, 16'd0, 1'b0);
      repeat (3) step_cycle(1'b0, 10'd0, 16'd0, 1'b0);
      chk("pre_rst_en", int'(o_en), 1);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_en",    int'(o_en),        0);
      chk("mid_rst_pos",   int'(o_pos),       0);
      chk("mid_rst_mode",  int'(o_mode),      1);
      chk("mid_rst_busy",  int'(o_busy),      0);
      chk("mid_rst_ready", int'(o_tgt_ready), 1);
      chk("mid_rst_cnt",   int'(cnt),         0);
      tgt_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      resync();
      chk_en = 1'b1;
      run_move(10'd4, 16'd1, 8, 0, 1'b0, em, rm, ec, dc, da, lm);
      chk("rst_new_en_mask", int'(em[31:0]), 32'hAA);
      chk("rst_new_done_at", da, 8);
      chk("rst_new_pos",     int'(o_pos), 4);

      // Randomized traffic around the current position.
      for (int i = 0; i < 3000; i++) begin
         int base, tv;
         extend_to(cyc);
         base = int'(x_pos[cyc]);
         tv   = base + int'($urandom_range(0, 24)) - 12;
         if (tv < 0)    tv = 0;
         if (tv > 1023) tv = 1023;
         step_cycle($urandom_range(0, 3) == 0, N'(tv), DW'($urandom_range(0, 4)),
                    $urandom_range(0, 19) == 0);
      end
      repeat (40) step_cycle(1'b0, 10'd0, 16'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
